emin_dp_sink: RTL

- Downstream consumer of the Emin(j,i) stream produced for one frame i, with samples for j = 0..i.
- Computes the dynamic-programming cost D[i] = min over j of (D[j-1] + Emin(j,i)), with D[-1] = 0, and the backpointer bp[i] = argmin j.
- Stores D and bp in internal tables.
- On request, traces the backpointers from a chosen end frame and emits the optimal segmentation, one segment per output pulse.

---
 rtl/emin_dp_sink.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/emin_dp_sink.sv
// rtl/emin_dp_sink.sv - DP cost/backpointer sink for the Emin(j,i) stream with segmentation traceback
//
// Purpose: for each frame i, consume Emin(j,i) for j = 0..i, compute
//   D[i] = min_j (D[j-1] + Emin(j,i)) with D[-1] = 0 and bp[i] = argmin j,
// store both in internal tables, and on request walk the backpointers
// from a chosen end frame, emitting one segment per output pulse.
//
// Ports:
//   clk_in, rst_in              clock, synchronous active-low reset
//   start_in, i_in              begin a frame (IDLE only), frame index
//   emin_valid_in, j_in, emin_in  Emin(j,i) sample stream
//   busy_out                    state is not IDLE
//   frame_done_out              one-cycle pulse when D[i]/bp[i] commit
//   cost_out, bp_out            last committed D[i]/bp[i], held
//   trace_start_in, trace_end_in  start a traceback from frame trace_end_in
//   seg_valid_out, seg_start_out, seg_end_out  one segment per pulse
//   trace_done_out              one-cycle pulse ending a traceback
//   error_out                   sticky error flag
module emin_dp_sink #(
    parameter int BIT_WIDTH  = 32,
    parameter int I          = 160,
    parameter int COST_WIDTH = 40,
    parameter int IW         = $clog2(I)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic [IW-1:0]                i_in,
    input  logic                         emin_valid_in,
    input  logic [IW-1:0]                j_in,
    input  logic signed [BIT_WIDTH-1:0]  emin_in,
    output logic                         busy_out,
    output logic                         frame_done_out,
    output logic signed [COST_WIDTH-1:0] cost_out,
    output logic [IW-1:0]                bp_out,
    input  logic                         trace_start_in,
    input  logic [IW-1:0]                trace_end_in,
    output logic                         seg_valid_out,
    output logic [IW-1:0]                seg_start_out,
    output logic [IW-1:0]                seg_end_out,
    output logic                         trace_done_out,
    output logic                         error_out
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COLLECT   = 3'd1;
    localparam logic [2:0] DRAIN     = 3'd2;
    localparam logic [2:0] COMMIT    = 3'd3;
    localparam logic [2:0] TRACE_RD  = 3'd4;
    localparam logic [2:0] TRACE_OUT = 3'd5;

    localparam logic signed [COST_WIDTH-1:0] COST_MAX = {1'b0, {(COST_WIDTH-1){1'b1}}};
    localparam logic [IW:0]                  IDX_LIMIT = (IW+1)'(I);

    logic signed [COST_WIDTH-1:0] d_mem [0:I-1];
    logic [IW-1:0]                bp_mem [0:I-1];

    logic [2:0]                   state_q, state_d;
    logic [IW-1:0]                i_q, i_d;
    logic [IW-1:0]                exp_j_q, exp_j_d;
    logic signed [COST_WIDTH-1:0] best_q, best_d;
    logic [IW-1:0]                best_j_q, best_j_d;
    logic [I-1:0]                 committed_q, committed_d;
    logic                         err_q, err_d;
    logic signed [COST_WIDTH-1:0] cost_q, cost_d;
    logic [IW-1:0]                bp_q, bp_d;
    logic [IW-1:0]                k_q, k_d;

    // S1 stage: accepted sample plus the operand read issued in S0
    logic                         s1_valid_q, s1_valid_d;
    logic [IW-1:0]                s1_j_q, s1_j_d;
    logic                         s1_first_q, s1_first_d;
    logic                         s1_comm_q, s1_comm_d;
    logic signed [BIT_WIDTH-1:0]  s1_emin_q, s1_emin_d;
    logic signed [COST_WIDTH-1:0] d_rd_q;

    // S2 stage: finished candidate awaiting the min compare
    logic                         s2_valid_q, s2_valid_d;
    logic                         s2_ok_q, s2_ok_d;
    logic [IW-1:0]                s2_j_q, s2_j_d;
    logic signed [COST_WIDTH-1:0] s2_cand_q, s2_cand_d;

    logic [IW-1:0]                bp_rd_q;

    logic                         s0_accept;
    logic [IW-1:0]                rd_addr;
    logic signed [COST_WIDTH-1:0] s1_opnd;
    logic signed [COST_WIDTH-1:0] emin_ext;
    logic                         k_ok;

    // j = 0 has no predecessor; point the read at a harmless address and force the operand later
    assign rd_addr   = (j_in == '0) ? '0 : (j_in - IW'(1));
    assign s0_accept = (state_q == COLLECT) && emin_valid_in && (j_in == exp_j_q) && (j_in <= i_q);
    assign s1_opnd   = s1_first_q ? '0 : d_rd_q;
    assign emin_ext  = {{(COST_WIDTH-BIT_WIDTH){s1_emin_q[BIT_WIDTH-1]}}, s1_emin_q};
    assign k_ok      = ({1'b0, k_q} < IDX_LIMIT) && committed_q[k_q];

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        exp_j_d     = exp_j_q;
        best_d      = best_q;
        best_j_d    = best_j_q;
        committed_d = committed_q;
        err_d       = err_q;
        cost_d      = cost_q;
        bp_d        = bp_q;
        k_d         = k_q;

        s1_valid_d  = 1'b0;
        s1_j_d      = s1_j_q;
        s1_first_d  = s1_first_q;
        s1_comm_d   = s1_comm_q;
        s1_emin_d   = s1_emin_q;

        s2_valid_d  = s1_valid_q;
        s2_ok_d     = s1_first_q | s1_comm_q;
        s2_j_d      = s1_j_q;
        s2_cand_d   = s1_opnd + emin_ext;

        if (s1_valid_q && !(s1_first_q | s1_comm_q)) begin
            err_d = 1'b1;
        end

        // Strict less-than keeps the earliest j on ties
        if (s2_valid_q && s2_ok_q && (s2_cand_q < best_q)) begin
            best_d   = s2_cand_q;
            best_j_d = s2_j_q;
        end

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    i_d      = i_in;
                    exp_j_d  = '0;
                    best_d   = COST_MAX;
                    best_j_d = '0;
                    state_d  = COLLECT;
                end else if (trace_start_in) begin
                    k_d     = trace_end_in;
                    state_d = TRACE_RD;
                end
            end
            COLLECT: begin
                if (s0_accept) begin
                    s1_valid_d = 1'b1;
                    s1_j_d     = j_in;
                    s1_first_d = (j_in == '0);
                    s1_comm_d  = committed_q[rd_addr];
                    s1_emin_d  = emin_in;
                    exp_j_d    = exp_j_q + IW'(1);
                    if (j_in == i_q) begin
                        state_d = DRAIN;
                    end
                end else if (emin_valid_in) begin
                    err_d = 1'b1;
                end
            end
            DRAIN: begin
                // S2 resolves this cycle once S1 is empty; publish its result so
                // the outputs line up with the COMMIT pulse.
                if (!s1_valid_q) begin
                    cost_d  = best_d;
                    bp_d    = best_j_d;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                committed_d[i_q] = 1'b1;
                state_d          = IDLE;
            end
            TRACE_RD: begin
                if (!k_ok) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = TRACE_OUT;
                end
            end
            TRACE_OUT: begin
                if (bp_rd_q == '0) begin
                    state_d = IDLE;
                end else begin
                    k_d     = bp_rd_q - IW'(1);
                    state_d = TRACE_RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            i_q         <= '0;
            exp_j_q     <= '0;
            best_q      <= '0;
            best_j_q    <= '0;
            committed_q <= '0;
            err_q       <= 1'b0;
            cost_q      <= '0;
            bp_q        <= '0;
            k_q         <= '0;
            s1_valid_q  <= 1'b0;
            s1_j_q      <= '0;
            s1_first_q  <= 1'b0;
            s1_comm_q   <= 1'b0;
            s1_emin_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_ok_q     <= 1'b0;
            s2_j_q      <= '0;
            s2_cand_q   <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            exp_j_q     <= exp_j_d;
            best_q      <= best_d;
            best_j_q    <= best_j_d;
            committed_q <= committed_d;
            err_q       <= err_d;
            cost_q      <= cost_d;
            bp_q        <= bp_d;
            k_q         <= k_d;
            s1_valid_q  <= s1_valid_d;
            s1_j_q      <= s1_j_d;
            s1_first_q  <= s1_first_d;
            s1_comm_q   <= s1_comm_d;
            s1_emin_q   <= s1_emin_d;
            s2_valid_q  <= s2_valid_d;
            s2_ok_q     <= s2_ok_d;
            s2_j_q      <= s2_j_d;
            s2_cand_q   <= s2_cand_d;
        end
    end

    // Single-port tables: D is read only in COLLECT and written only in COMMIT;
    // bp is read only in TRACE_RD and written only in COMMIT.
    always_ff @(posedge clk_in) begin
        if (state_q == COMMIT) begin
            d_mem[i_q]  <= best_q;
            bp_mem[i_q] <= best_j_q;
        end else if (s0_accept) begin
            d_rd_q <= d_mem[rd_addr];
        end
        if (state_q == TRACE_RD) begin
            bp_rd_q <= bp_mem[k_q];
        end
    end

    assign busy_out       = (state_q != IDLE);
    assign frame_done_out = (state_q == COMMIT);
    assign cost_out       = cost_q;
    assign bp_out         = bp_q;
    assign seg_valid_out  = (state_q == TRACE_OUT);
    assign seg_start_out  = (state_q == TRACE_OUT) ? bp_rd_q : '0;
    assign seg_end_out    = (state_q == TRACE_OUT) ? k_q : '0;
    assign trace_done_out = ((state_q == TRACE_RD) && !k_ok) ||
                            ((state_q == TRACE_OUT) && (bp_rd_q == '0));
    assign error_out      = err_q;

endmodule
